muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; also the iteration count.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 op  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
REQ-006 a  input  WIDTH  multiplicand / dividend; sampled with start.
REQ-007 b  input  WIDTH  multiplier / divisor; sampled with start.
REQ-008 busy  output  1  operation in progress.
REQ-009 done  output  1  one-cycle pulse; hi/lo valid.
REQ-010 hi  output  WIDTH  mult: upper product half; div: remainder.
REQ-011 lo  output  WIDTH  mult: lower product half; div: quotient.
REQ-012 div_by_zero  output  1  set with done when a DIV/DIVU had b=0; held until the next done.

Function
REQ-013 All outputs SHALL be registered; hi, lo, div_by_zero SHALL hold their value until the next done.
REQ-014 FSM states SHALL be IDLE, RUN, FIN; busy=1 exactly in RUN and FIN.
REQ-015 IDLE: start=1 at edge k SHALL latch op, |a|, |b| (signed ops) or a, b (unsigned ops), record result signs, clear the iteration counter, and enter RUN.
REQ-016 RUN SHALL perform one shift-add (mult) or one restoring shift-subtract (div) step per cycle for exactly WIDTH cycles, then enter FIN (at edge k+WIDTH).
REQ-017 FIN SHALL apply sign correction, write hi/lo, assert done for one cycle, and return to IDLE at edge k+WIDTH+1; total latency WIDTH+1 cycles (33 at default).
REQ-018 done and busy=0 SHALL become visible after the same edge; start in that done cycle SHALL be accepted (back-to-back).
REQ-019 start while busy=1 SHALL be ignored, with no effect on operands or timing.
REQ-020 MULT: product sign = sign(a) XOR sign(b); the 2*WIDTH-bit magnitude SHALL be two's-complement negated as one value across {hi,lo}.
REQ-021 DIV: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a) (truncation toward zero).
REQ-022 Magnitude of -2^(WIDTH-1) SHALL be taken as the unsigned value 2^(WIDTH-1).
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 with no flag.
REQ-024 DIV/DIVU with b=0 SHALL go IDLE->FIN at edge k, skipping RUN; FIN writes hi=a, lo=all-ones, div_by_zero=1, done after edge k+1.
REQ-025 div_by_zero SHALL be 0 on every done not covered by REQ-024.
REQ-026 Operand inputs SHALL be don't-care after the start edge.

Reset
REQ-027 reset=1 at any edge SHALL force IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0.
REQ-028 reset SHALL have priority over start and SHALL abort an operation in flight with no done pulse.

Verification
REQ-029 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done exactly 33 cycles after the start edge, hi=0xFFFFFFFE, lo=0x00000001, busy high for 33 cycles.
REQ-030 MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIVU a=100 b=7 issued in the done cycle -> lo=14, hi=2 after 33 more cycles.
REQ-031 DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
REQ-032 DIV a=5 b=0 -> done after 2 edges, hi=5, lo=0xFFFFFFFF, div_by_zero=1; following MULTU 2*3 -> lo=6, div_by_zero=0.
REQ-033 MULTU 6*7 started, start pulsed again with new operands at cycle 5 -> ignored, result lo=42 at cycle 33.
REQ-034 Reset asserted at cycle 10 of a MULTU -> next cycle busy=0, hi=lo=0, no done; a new start is then accepted normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide.
// One step per cycle for WIDTH cycles, then sign fix-up and done.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    // Operand sign/magnitude; op[0] selects signed interpretation
    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   abs_a, abs_b;

    // Datapath step results
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mstep;
    logic [WIDTH:0]     rsh;
    logic [WIDTH:0]     rdiff;
    logic               qge;
    logic [2*WIDTH-1:0] dstep;
    logic [2*WIDTH-1:0] pneg;
    logic [WIDTH-1:0]   qv, rv;

    // Operand magnitudes and single-step multiply/divide datapath
    always_comb begin
        sgn_a = op[0] & a[WIDTH-1];
        sgn_b = op[0] & b[WIDTH-1];
        abs_a = sgn_a ? -a : a;
        abs_b = sgn_b ? -b : b;

        msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, mb_q} : {(WIDTH+1){1'b0}});
        mstep = {msum, acc_q[WIDTH-1:1]};

        rsh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        qge   = (rsh >= {1'b0, mb_q});
        rdiff = rsh - {1'b0, mb_q};
        dstep = qge ? {rdiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                    : {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

        pneg  = -acc_q;
        qv    = acc_q[WIDTH-1:0];
        rv    = acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state and register-update logic for the IDLE/RUN/FIN sequence
    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = op[1];
                    qneg_d   = sgn_a ^ sgn_b;
                    rneg_d   = sgn_a;
                    cnt_d    = '0;
                    mb_d     = abs_b;
                    dz_d     = op[1] && (b == '0);
                    if (op[1] && (b == '0)) begin
                        acc_d   = {{WIDTH{1'b0}}, a};
                        state_d = FIN;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, abs_a};
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = is_div_q ? dstep : mstep;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dbz_d   = dz_q;
                if (dz_q) begin
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = '1;
                end else if (is_div_q) begin
                    lo_d = qneg_q ? -qv : qv;
                    hi_d = rneg_q ? -rv : rv;
                end else begin
                    {hi_d, lo_d} = qneg_q ? pneg : acc_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            mb_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            mb_q     <= mb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
